uart_rx_host_ctrl: RTL

- Host-side controller that sits between the UART receiver and the system bus/consumer.
- Stages receiver configuration (prescale, parity enable/type) and applies it only while the receiver is between frames.
- Buffers received bytes in a small FIFO with a valid/ready pop interface.
- Tracks overflow: a sticky flag plus a saturating drop counter.

---
 rtl/uart_rx_host_ctrl_pkg.sv | 24 ++
 rtl/uart_rx_host_ctrl_if.sv | 29 ++
 rtl/uart_rx_host_ctrl_fifo.sv | 73 +++++++
 rtl/uart_rx_host_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_rx_host_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_host_pkg
// Shared types and constants for the UART receiver host-side controller.
//   cfg_state_t  : states of the configuration staging FSM
//   DROP_CNT_W   : width of the saturating dropped-word counter
//   DROP_CNT_MAX : saturation value of the dropped-word counter
//   ptr_width()  : FIFO pointer width for a given depth
// ---------------------------------------------------------------------------
package uart_rx_host_pkg;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_t;

  localparam int DROP_CNT_W   = 8;
  localparam int DROP_CNT_MAX = 255;

  // A depth of 1 would give a zero-width pointer, so clamp to one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_host_ctrl_if
// Valid/ready pop stream from the receive byte buffer to its consumer.
//   data       : FIFO head word
//   data_valid : FIFO not empty
//   data_ready : consumer accepts the head this cycle
// master = buffer side (drives data/data_valid), slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_host_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/uart_rx_host_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// rx_sync_fifo
// First-word-fall-through synchronous FIFO holding received words.
//   clk, rst : clock and synchronous active-high reset
//   push     : write wdata (ignored when full unless a pop happens too)
//   pop      : drop the head word (ignored when empty)
//   wdata    : word to write
//   rdata    : head word, zero while empty
//   full     : occupancy equals FIFO_DEPTH
//   empty    : occupancy is zero
//   count    : current occupancy
// ---------------------------------------------------------------------------
module rx_sync_fifo
  import uart_rx_host_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int            PW      = ptr_width(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           cnt;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  // Present zero while empty so stale storage never leaks to the consumer.
  assign rdata   = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  // Storage needs no reset; emptiness is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_host_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_host_ctrl
// Host-side controller between a UART receiver and its consumer.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_cfg_wr, i_cfg_*     : stage a new receiver configuration
//   i_rx_idle             : receiver is between frames
//   o_prescale, o_parity_*: active configuration driven to the receiver
//   o_cfg_pending         : a staged configuration is waiting to be applied
//   i_rx_data_valid/data  : received word from the receiver
//   pop_if                : valid/ready stream of buffered words
//   o_count               : buffer occupancy
//   o_overflow            : sticky, set when a word is dropped
//   o_drop_count          : saturating count of dropped words
//   i_clr_overflow        : clears o_overflow and o_drop_count
// ---------------------------------------------------------------------------
module uart_rx_host_ctrl
  import uart_rx_host_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PRESCALE     = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int RST_PRESCALE = PRESCALE - 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cfg_wr,
  input  logic [$clog2(PRESCALE)-1:0]  i_cfg_prescale,
  input  logic                         i_cfg_parity_enable,
  input  logic                         i_cfg_parity_type,
  input  logic                         i_rx_idle,
  output logic [$clog2(PRESCALE)-1:0]  o_prescale,
  output logic                         o_parity_enable,
  output logic                         o_parity_type,
  output logic                         o_cfg_pending,
  input  logic                         i_rx_data_valid,
  input  logic [DATA_WIDTH-1:0]        i_rx_data,
  uart_rx_host_ctrl_if.master          pop_if,
  output logic [$clog2(FIFO_DEPTH):0]  o_count,
  output logic                         o_overflow,
  input  logic                         i_clr_overflow,
  output logic [DROP_CNT_W-1:0]        o_drop_count
);

  localparam int PS_W = $clog2(PRESCALE);

  cfg_state_t            state;
  logic [PS_W-1:0]       shadow_prescale;
  logic                  shadow_parity_enable;
  logic                  shadow_parity_type;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  assign o_cfg_pending = (state == CFG_PENDING);

  // Config staging: writes land in the shadow, and the shadow reaches the
  // receiver only when it is idle and no word is being delivered, so a frame
  // is never decoded with a half-changed configuration. A write coinciding
  // with an apply lets the older shadow go out and keeps the new one staged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= CFG_IDLE;
      shadow_prescale      <= PS_W'(RST_PRESCALE);
      shadow_parity_enable <= 1'b0;
      shadow_parity_type   <= 1'b0;
      o_prescale           <= PS_W'(RST_PRESCALE);
      o_parity_enable      <= 1'b0;
      o_parity_type        <= 1'b0;
    end else begin
      case (state)
        CFG_IDLE: begin
          if (i_cfg_wr) begin
            shadow_prescale      <= i_cfg_prescale;
            shadow_parity_enable <= i_cfg_parity_enable;
            shadow_parity_type   <= i_cfg_parity_type;
            state                <= CFG_PENDING;
          end
        end
        CFG_PENDING: begin
          if (i_rx_idle && !i_rx_data_valid) begin
            o_prescale      <= shadow_prescale;
            o_parity_enable <= shadow_parity_enable;
            o_parity_type   <= shadow_parity_type;
            state           <= CFG_IDLE;
          end
          if (i_cfg_wr) begin
            shadow_prescale      <= i_cfg_prescale;
            shadow_parity_enable <= i_cfg_parity_enable;
            shadow_parity_type   <= i_cfg_parity_type;
            state                <= CFG_PENDING;
          end
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

  // A word is only lost when the buffer is full and the head is not leaving.
  assign pop  = !fifo_empty && pop_if.data_ready;
  assign push = i_rx_data_valid && (!fifo_full || pop);
  assign drop = i_rx_data_valid && fifo_full && !pop;

  assign pop_if.data       = fifo_rdata;
  assign pop_if.data_valid = !fifo_empty;

  rx_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_rx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  // Overflow tracking. A drop beats a simultaneous clear: the clear wipes the
  // old history and the new drop is counted from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (i_clr_overflow) begin
        o_drop_count <= DROP_CNT_W'(1);
      end else if (o_drop_count != DROP_CNT_W'(DROP_CNT_MAX)) begin
        o_drop_count <= o_drop_count + 1'b1;
      end
    end else if (i_clr_overflow) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end
  end

endmodule
